// File: rtl/corr_sync_sched.sv
// corr_sync_sched: arbitrates the shared sync-word correlator between three baseband requesters
// (bit0 CAC, bit1 DAC, bit2 IAC). Each service runs through these steps:
//   1. Grant one requester.
//   2. Load its sync word onto ref_sync.
//   3. Open correWindow for the requester's window length in 1 us ticks.
//   4. On a trigger rising edge, lock until the slot-delay end.
//   5. Report done/hit/abort back to the requester.
//   6. Enforce GUARD_US idle ticks before the next service.
//
// Ports:
//   clk_6M, rst              6 MHz clock, synchronous active-high reset
//   p_1us                    one-cycle 1 us tick
//   req[2:0]                 request levels, held until done_p
//   sync0..2, win_len0..2    per-requester sync word and window length (us, 0 acts as 1)
//   pscorr_trgp              correlator trigger level
//   corre_tslotdly_endp      correlator slot-delay end pulse
//   ref_sync                 sync word presented to the correlator
//   correWindow              correlator search enable (high only in OPEN)
//   gnt                      one-hot grant, held from LOAD through DONE
//   done_p, hit, aborted     one-cycle completion report for the served requester
//   busy                     scheduler not idle
module corr_sync_sched #(
  parameter int unsigned WIN_W    = 10,
  parameter int unsigned GUARD_US = 4
) (
  input  logic             clk_6M,
  input  logic             rst,
  input  logic             p_1us,
  input  logic [2:0]       req,
  input  logic [63:0]      sync0,
  input  logic [63:0]      sync1,
  input  logic [63:0]      sync2,
  input  logic [WIN_W-1:0] win_len0,
  input  logic [WIN_W-1:0] win_len1,
  input  logic [WIN_W-1:0] win_len2,
  input  logic             pscorr_trgp,
  input  logic             corre_tslotdly_endp,
  output logic [63:0]      ref_sync,
  output logic             correWindow,
  output logic [2:0]       gnt,
  output logic [2:0]       done_p,
  output logic             hit,
  output logic             aborted,
  output logic             busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StOpen,
    StLock,
    StDoneHit,
    StDoneMiss,
    StDoneAbort,
    StGuard
  } state_e;

  // Last guard count value; only used when GUARD_US > 0.
  localparam logic [3:0] GuardLast = 4'(GUARD_US - 1);

  state_e           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [63:0]      ref_sync_q, ref_sync_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [3:0]       guard_cnt_q, guard_cnt_d;
  logic             trg_q;
  logic             corr_win_q, corr_win_d;
  logic [2:0]       done_q, done_d;
  logic             hit_q, hit_d;
  logic             aborted_q, aborted_d;

  logic             trg_rise;
  logic             req_gnt;
  logic             win_last;
  logic [2:0]       winner;
  logic [63:0]      winner_sync;
  logic [WIN_W-1:0] winner_len;

  assign trg_rise = pscorr_trgp & ~trg_q;
  assign req_gnt  = |(req & gnt_q);
  assign win_last = (win_cnt_q == len_q - WIN_W'(1));

  // Fixed priority: bit0 > bit1 > bit2.
  always_comb begin
    winner      = 3'b000;
    winner_sync = '0;
    winner_len  = '0;
    if (req[0]) begin
      winner      = 3'b001;
      winner_sync = sync0;
      winner_len  = win_len0;
    end else if (req[1]) begin
      winner      = 3'b010;
      winner_sync = sync1;
      winner_len  = win_len1;
    end else if (req[2]) begin
      winner      = 3'b100;
      winner_sync = sync2;
      winner_len  = win_len2;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ref_sync_d  = ref_sync_q;
    len_d       = len_q;
    win_cnt_d   = win_cnt_q;
    guard_cnt_d = guard_cnt_q;

    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d    = StLoad;
          gnt_d      = winner;
          ref_sync_d = winner_sync;
          len_d      = (winner_len == '0) ? WIN_W'(1) : winner_len;
        end
      end
      StLoad: begin
        if (!req_gnt) begin
          state_d = StDoneAbort;
        end else if (p_1us) begin
          state_d   = StOpen;
          win_cnt_d = '0;
        end
      end
      StOpen: begin
        if (p_1us) begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
        // Trigger beats expiry beats abort when they coincide.
        if (trg_rise) begin
          state_d = StLock;
        end else if (p_1us && win_last) begin
          state_d = StDoneMiss;
        end else if (!req_gnt) begin
          state_d = StDoneAbort;
        end
      end
      StLock: begin
        if (corre_tslotdly_endp) begin
          state_d = StDoneHit;
        end
      end
      StDoneHit, StDoneMiss, StDoneAbort: begin
        gnt_d       = 3'b000;
        guard_cnt_d = '0;
        state_d     = (GUARD_US == 0) ? StIdle : StGuard;
      end
      StGuard: begin
        if (p_1us) begin
          if (guard_cnt_q == GuardLast) begin
            state_d = StIdle;
          end else begin
            guard_cnt_d = guard_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs decoded from the next state so they track the state register exactly.
  always_comb begin
    corr_win_d = (state_d == StOpen);
    hit_d      = (state_d == StDoneHit);
    aborted_d  = (state_d == StDoneAbort);
    done_d     = 3'b000;
    if (state_d == StDoneHit || state_d == StDoneMiss || state_d == StDoneAbort) begin
      done_d = gnt_d;
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= 3'b000;
      ref_sync_q  <= '0;
      len_q       <= '0;
      win_cnt_q   <= '0;
      guard_cnt_q <= '0;
      trg_q       <= 1'b0;
      corr_win_q  <= 1'b0;
      done_q      <= 3'b000;
      hit_q       <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ref_sync_q  <= ref_sync_d;
      len_q       <= len_d;
      win_cnt_q   <= win_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      trg_q       <= pscorr_trgp;
      corr_win_q  <= corr_win_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      aborted_q   <= aborted_d;
    end
  end

  assign ref_sync    = ref_sync_q;
  assign correWindow = corr_win_q;
  assign gnt         = gnt_q;
  assign done_p      = done_q;
  assign hit         = hit_q;
  assign aborted     = aborted_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_corr_sync_sched.sv
// Scoreboard bench for corr_sync_sched. Stimulus plans each service (window length, trigger tick,
// abort point), predicts the outcome from the scheduling rules and queues it; a monitor process
// checks every done_p report against the queue.
module tb_corr_sync_sched;

  localparam int unsigned WinW    = 10;
  localparam int unsigned GuardUs = 4;

  typedef struct packed {
    logic [2:0] d;
    logic       h;
    logic       a;
  } exp_t;

  logic            clk_6M = 1'b0;
  logic            rst;
  logic            p_1us;
  logic [2:0]      req;
  logic [63:0]     sync_w [3];
  logic [WinW-1:0] win_len_v [3];
  logic            pscorr_trgp;
  logic            corre_tslotdly_endp;
  logic [63:0]     ref_sync;
  logic            correWindow;
  logic [2:0]      gnt;
  logic [2:0]      done_p;
  logic            hit;
  logic            aborted;
  logic            busy;

  int   total = 0;
  int   bad = 0;
  int   win_ticks = 0;
  exp_t exp_q[$];

  always #5 clk_6M = ~clk_6M;

  corr_sync_sched #(
    .WIN_W    (WinW),
    .GUARD_US (GuardUs)
  ) dut (
    .clk_6M              (clk_6M),
    .rst                 (rst),
    .p_1us               (p_1us),
    .req                 (req),
    .sync0               (sync_w[0]),
    .sync1               (sync_w[1]),
    .sync2               (sync_w[2]),
    .win_len0            (win_len_v[0]),
    .win_len1            (win_len_v[1]),
    .win_len2            (win_len_v[2]),
    .pscorr_trgp         (pscorr_trgp),
    .corre_tslotdly_endp (corre_tslotdly_endp),
    .ref_sync            (ref_sync),
    .correWindow         (correWindow),
    .gnt                 (gnt),
    .done_p              (done_p),
    .hit                 (hit),
    .aborted             (aborted),
    .busy                (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_6M);
      #1;
    end
  endtask

  task automatic tick(input bit trg);
    int gap;
    gap = $urandom_range(3, 6);
    cyc(gap - 1);
    p_1us = 1'b1;
    if (trg) pscorr_trgp = 1'b1;
    cyc(1);
    p_1us = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk_6M);
      if (done_p != 3'b000) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got none want done_p at %0t", $time);
    end
  endtask

  // trig_at: tick index (1-based within the window) where the trigger rises, 0 = never.
  // abort_at: -1 = never, 0 = drop in LOAD, k = drop between window ticks k-1 and k.
  task automatic run_txn(input logic [2:0] r, input logic [2:0] keep, input int trig_at,
                         input int abort_at, input bit lock_drop, input bit do_reset);
    int         w;
    int         len_eff;
    int         exp_ticks;
    int         snap;
    bit         is_hit;
    bit         is_ab;
    bit         stop;
    logic [2:0] wbit;
    exp_t       e;

    w = 2;
    if (r[1]) w = 1;
    if (r[0]) w = 0;
    wbit    = 3'(1 << w);
    len_eff = (win_len_v[w] == 0) ? 1 : int'(win_len_v[w]);

    // Earliest event wins; an abort precedes the tick it is placed before.
    is_ab  = (abort_at >= 0) && (trig_at == 0 || abort_at <= trig_at) && abort_at <= len_eff;
    is_hit = !is_ab && trig_at != 0 && trig_at <= len_eff;
    if (is_ab) exp_ticks = (abort_at > 0) ? abort_at - 1 : 0;
    else if (is_hit) exp_ticks = trig_at;
    else exp_ticks = len_eff;
    e.d = wbit;
    e.h = is_hit;
    e.a = is_ab;

    req = r;
    cyc(1);
    check("gnt_load", 64'(gnt), 64'(wbit));
    check("ref_sync_load", ref_sync, sync_w[w]);
    check("busy_load", 64'(busy), 64'd1);
    check("cw_load", 64'(correWindow), 64'd0);
    if (!do_reset) exp_q.push_back(e);
    snap = win_ticks;

    if (abort_at == 0) begin
      cyc(2);
      req = req & ~wbit;
    end else begin
      tick(1'b0);
      stop = 1'b0;
      for (int k = 1; k <= len_eff && !stop; k++) begin
        if (k == abort_at) begin
          cyc(2);
          req  = req & ~wbit;
          stop = 1'b1;
        end else begin
          tick(k == trig_at);
          if (k == trig_at) stop = 1'b1;
        end
      end
    end

    if (is_hit) begin
      check("cw_after_trg", 64'(correWindow), 64'd0);
      tick(1'b0);
      pscorr_trgp = 1'b0;
      if (do_reset) begin
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        req = 3'b000;
        check("rst_lock_outs", {ref_sync, 3'(gnt), 3'(done_p), correWindow, hit, aborted, busy},
              70'd0);
        cyc(30);
        check("rst_lock_idle", 64'(busy), 64'd0);
        return;
      end
      cyc(2);
      pscorr_trgp = 1'b1;
      cyc(2);
      pscorr_trgp = 1'b0;
      if (lock_drop) req = req & ~wbit;
      cyc($urandom_range(1, 100));
      check("cw_lock", 64'(correWindow), 64'd0);
      check("gnt_lock", 64'(gnt), 64'(wbit));
      corre_tslotdly_endp = 1'b1;
      cyc(1);
      corre_tslotdly_endp = 1'b0;
    end

    wait_done();
    check("win_ticks", 64'(win_ticks - snap), 64'(exp_ticks));
    @(posedge clk_6M);
    #1;
    check("guard_outs", {3'(gnt), 3'(done_p), hit, aborted, busy}, 9'd1);
    check("guard_ref_sync", ref_sync, sync_w[w]);
    req = keep;
    for (int g = 1; g <= int'(GuardUs); g++) begin
      if (g == int'(GuardUs)) begin
        check("busy_guard", 64'(busy), 64'd1);
        check("gnt_guard", 64'(gnt), 64'd0);
      end
      tick(1'b0);
    end
    check("idle_after_guard", 64'(busy), 64'd0);
  endtask

  // Monitor: every done_p report must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_6M);
      if (done_p != 3'b000) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got %b want none at %0t", done_p, $time);
        end else begin
          e = exp_q.pop_front();
          check("done_p", 64'(done_p), 64'(e.d));
          check("hit", 64'(hit), 64'(e.h));
          check("aborted", 64'(aborted), 64'(e.a));
        end
      end
    end
  end

  // Counts 1 us ticks seen while the search window is open.
  initial begin
    forever begin
      @(negedge clk_6M);
      if (p_1us && correWindow) win_ticks++;
    end
  end

  initial begin
    logic [2:0] r;
    logic [2:0] keep;
    int         mode;
    int         le;
    int         ta;
    int         ab;

    rst                 = 1'b1;
    p_1us               = 1'b0;
    req                 = 3'b000;
    pscorr_trgp         = 1'b0;
    corre_tslotdly_endp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sync_w[i]    = {$urandom, $urandom};
      win_len_v[i] = WinW'(10);
    end
    cyc(3);
    check("reset_outs", {ref_sync, 3'(gnt), 3'(done_p), correWindow, hit, aborted, busy}, 70'd0);
    rst = 1'b0;
    cyc(2);

    win_len_v[1] = WinW'(10);
    run_txn(3'b010, 3'b000, 0, -1, 1'b0, 1'b0);
    win_len_v[1] = WinW'(5);
    win_len_v[2] = WinW'(6);
    run_txn(3'b110, 3'b100, 0, -1, 1'b0, 1'b0);
    run_txn(3'b100, 3'b000, 0, -1, 1'b0, 1'b0);
    win_len_v[0] = WinW'(20);
    run_txn(3'b001, 3'b000, 7, -1, 1'b0, 1'b0);
    win_len_v[0] = WinW'(8);
    run_txn(3'b001, 3'b000, 8, -1, 1'b0, 1'b0);
    win_len_v[0] = WinW'(12);
    run_txn(3'b001, 3'b000, 0, 4, 1'b0, 1'b0);
    run_txn(3'b001, 3'b000, 3, -1, 1'b1, 1'b0);
    win_len_v[2] = WinW'(0);
    run_txn(3'b100, 3'b000, 0, -1, 1'b0, 1'b0);
    run_txn(3'b001, 3'b000, 2, -1, 1'b0, 1'b1);
    run_txn(3'b010, 3'b000, 0, 0, 1'b0, 1'b0);

    r = 3'b000;
    for (int n = 0; n < 25; n++) begin
      if (r == 3'b000) r = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
        sync_w[i]    = {$urandom, $urandom};
        win_len_v[i] = WinW'($urandom_range(0, 24));
      end
      if (r[0]) le = int'(win_len_v[0]);
      else if (r[1]) le = int'(win_len_v[1]);
      else le = int'(win_len_v[2]);
      if (le == 0) le = 1;
      mode = $urandom_range(0, 3);
      ta   = (mode == 1 || mode == 3) ? $urandom_range(1, le) : 0;
      ab   = (mode == 2 || mode == 3) ? $urandom_range(0, le) : -1;
      // Pending lower-priority requests carried across the guard period.
      keep = 3'($urandom_range(0, 7)) & r;
      if (r[0]) keep[0] = 1'b0;
      else if (r[1]) keep[1] = 1'b0;
      else keep[2] = 1'b0;
      run_txn(r, keep, ta, ab, 1'($urandom_range(0, 1)), 1'b0);
      r = keep;
    end

    cyc(10);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corr_sync_sched.md
Name: corr_sync_sched

Overview:
- Schedules the shared sync-word correlator among three baseband requesters: connection (CAC), page scan (DAC) and inquiry scan (IAC).
- Per service: grants one requester, loads its sync word onto ref_sync, opens correWindow for a programmed number of microseconds, then detects a correlation trigger.
- On a trigger, holds the correlator locked until the slot-delay end. Reports done/hit/abort back to the granted requester.
- Sits between the link-control FSMs and the correlator.

Parameters:
WIN_W, 10, width of window-length inputs and window counter (us units)
GUARD_US, 4, idle p_1us ticks enforced between consecutive services (0..15)

Ports:
clk_6M  in  1  6 MHz system clock
rst  in  1  synchronous reset, active-high
p_1us  in  1  one-cycle 1 us tick
req  in  3  requests; bit0 CAC, bit1 DAC, bit2 IAC; level, held until done_p
sync0  in  64  sync word for requester 0
sync1  in  64  sync word for requester 1
sync2  in  64  sync word for requester 2
win_len0  in  WIN_W  window length in us, requester 0
win_len1  in  WIN_W  window length in us, requester 1
win_len2  in  WIN_W  window length in us, requester 2
pscorr_trgp  in  1  correlator trigger level; held at least 1 us
corre_tslotdly_endp  in  1  correlator slot-delay end pulse
ref_sync  out  64  reference sync word to correlator
correWindow  out  1  correlator search enable
gnt  out  3  one-hot grant; held from LOAD through LOCK
done_p  out  3  one-cycle completion pulse, bit of the served requester
hit  out  1  valid with done_p; 1 = correlation found
aborted  out  1  valid with done_p; 1 = requester withdrew
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk_6M edge):
  - state IDLE.
  - ref_sync=0, correWindow=0, gnt=0, done_p=0, hit=0, aborted=0, busy=0.
  - All counters and the trigger-edge register cleared.
  - Reset mid-operation abandons the service with no done_p.
- Trigger edge: trg_rise = pscorr_trgp & ~pscorr_trgp_d, with pscorr_trgp_d registered every cycle.
- Arbitration: fixed priority, bit0 > bit1 > bit2. Evaluated only in IDLE.
- IDLE:
  - Any req bit set -> next cycle enter LOAD.
  - gnt = winner; ref_sync = winner's sync word; win_len latched (0 treated as 1).
- LOAD:
  - Wait for p_1us, then OPEN with win_cnt=0.
  - If req[gnt] drops -> DONE_ABORT.
- OPEN:
  - correWindow=1.
  - On each p_1us, win_cnt++.
  - trg_rise -> LOCK; correWindow=0 the next cycle.
  - Otherwise p_1us with win_cnt==len-1 -> DONE_MISS.
  - Otherwise req[gnt] low -> DONE_ABORT.
  - Priority when simultaneous: trigger > expiry > abort.
- LOCK:
  - correWindow=0; ref_sync and gnt held; req drop ignored.
  - corre_tslotdly_endp -> DONE_HIT.
- DONE_HIT / DONE_MISS / DONE_ABORT:
  - Single cycle.
  - done_p = gnt; hit=1 only for DONE_HIT; aborted=1 only for DONE_ABORT.
  - Next cycle: gnt=0, hit=0, aborted=0, guard_cnt=0, go to GUARD. ref_sync keeps its last value.
- GUARD:
  - Count p_1us to GUARD_US, then IDLE.
  - GUARD_US=0 -> IDLE the cycle after DONE.
  - Requests are not sampled in GUARD.
- correWindow is asserted only in OPEN. It drops in the same cycle the state leaves OPEN (registered output, decoded from next state).
- Window arithmetic:
  - win_cnt is WIN_W bits; the window spans exactly len p_1us ticks.
  - len = 2^WIN_W-1 never wraps, since the compare hits first.
- A requester that re-asserts after done_p is re-arbitrated normally. Lower-priority requesters can starve; that is accepted behaviour.

Test Plan:
- After reset, req=3'b010, win_len1=10, no trigger -> gnt=010; ref_sync=sync1; correWindow high for exactly 10 p_1us ticks; done_p=010, hit=0, aborted=0; IDLE after 4 further ticks.
- req=3'b110 together -> DAC granted first. Then with req[2] still high, IAC granted only after the GUARD period (4 ticks); ref_sync switches to sync2.
- OPEN with win_len0=20, pscorr_trgp rises at tick 7 and is held 2 us -> correWindow low next cycle. No further trigger counted. corre_tslotdly_endp 100 cycles later -> done_p=001, hit=1.
- Trigger rise and window expiry on the same cycle -> LOCK entered; hit=1 at corre_tslotdly_endp.
- req[0] dropped in OPEN at tick 3 -> done_p=001, aborted=1, hit=0. req drop during LOCK -> ignored; completes with hit=1.
- rst asserted during LOCK -> next cycle all outputs 0, state IDLE, no done_p. win_len=0 -> window of 1 tick.
